// File: rtl/mole_hit_judge_if.sv
// Keypad-press and judgement bus between the keypad side, the hit judge and the mole generator.
`timescale 1ns/1ps
interface mole_hit_judge_if #(
    parameter int NUM_HOLES = 9,
    parameter int CNT_W     = 8
);
    logic                 valid_key;
    logic [3:0]           key;
    logic [NUM_HOLES-1:0] mole_active;
    logic                 game_en;
    logic                 score_clr;
    logic                 hit;
    logic                 miss;
    logic [3:0]           hit_pos;
    logic [NUM_HOLES-1:0] mole_clear;
    logic [CNT_W-1:0]     score;
    logic [CNT_W-1:0]     misses;
    logic                 busy;

    modport master (
        output valid_key, key, mole_active, game_en, score_clr,
        input  hit, miss, hit_pos, mole_clear, score, misses, busy
    );

    modport slave (
        input  valid_key, key, mole_active, game_en, score_clr,
        output hit, miss, hit_pos, mole_clear, score, misses, busy
    );
endinterface

// File: rtl/mole_hit_judge.sv
// Whac-A-Mole press judge: synchronises keypad presses, scores hit/miss, then locks out re-presses.
// Optional MOLE_SCORE_BCD_EN turns score/misses into 2-digit packed BCD counters saturating at 99.
`timescale 1ns/1ps
module mole_hit_judge #(
    parameter int NUM_HOLES      = 9,
    parameter int CNT_W          = 8,
    parameter int LOCKOUT_CYCLES = 50000
) (
    input logic              clk,
    input logic              reset,
    mole_hit_judge_if.slave  bus
);
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0]    LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]           KEY_LIMIT = 4'(NUM_HOLES);
    localparam logic [NUM_HOLES-1:0] ONE_HOT0  = NUM_HOLES'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        JUDGE   = 3'd2,
        LOCKOUT = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t               state, state_d;
    logic                 s1, s2, s3;
    logic                 rise;
    logic [3:0]           key_q;
    logic [LOCK_W-1:0]    lock_cnt, lock_cnt_d;
    logic                 hit_d, miss_d, key_ld, pos_ld, score_inc, miss_inc;
    logic [NUM_HOLES-1:0] clear_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
`ifdef MOLE_SCORE_BCD_EN
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'h1};
`else
        if (&v)
            return v;
        else
            return v + CNT_W'(1);
`endif
    endfunction

    assign rise     = s2 & ~s3;
    assign bus.busy = (state != IDLE);

    always_comb begin
        state_d    = state;
        lock_cnt_d = lock_cnt;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        clear_d    = '0;
        key_ld     = 1'b0;
        pos_ld     = 1'b0;
        score_inc  = 1'b0;
        miss_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rise)
                    state_d = bus.game_en ? CAPTURE : RELEASE;
            end
            CAPTURE: begin
                key_ld  = 1'b1;
                state_d = (bus.key >= KEY_LIMIT) ? RELEASE : JUDGE;
            end
            JUDGE: begin
                pos_ld = 1'b1;
                if (bus.mole_active[key_q]) begin
                    hit_d     = 1'b1;
                    clear_d   = ONE_HOT0 << key_q;
                    score_inc = 1'b1;
                end else begin
                    miss_d   = 1'b1;
                    miss_inc = 1'b1;
                end
                lock_cnt_d = LOCK_LOAD;
                state_d    = LOCKOUT;
            end
            LOCKOUT: begin
                // The synchroniser keeps running here so RELEASE sees the live key level.
                if (lock_cnt == '0)
                    state_d = RELEASE;
                else
                    lock_cnt_d = lock_cnt - LOCK_W'(1);
            end
            RELEASE: begin
                if (!s2)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            s1             <= 1'b0;
            s2             <= 1'b0;
            s3             <= 1'b0;
            key_q          <= '0;
            lock_cnt       <= '0;
            bus.hit        <= 1'b0;
            bus.miss       <= 1'b0;
            bus.mole_clear <= '0;
            bus.hit_pos    <= '0;
        end else begin
            state          <= state_d;
            s1             <= bus.valid_key;
            s2             <= s1;
            s3             <= s2;
            lock_cnt       <= lock_cnt_d;
            bus.hit        <= hit_d;
            bus.miss       <= miss_d;
            bus.mole_clear <= clear_d;
            if (key_ld)
                key_q <= bus.key;
            if (pos_ld)
                bus.hit_pos <= key_q;
        end
    end

    // Clear has priority over a coincident judgement increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.score  <= '0;
            bus.misses <= '0;
        end else if (bus.score_clr) begin
            bus.score  <= '0;
            bus.misses <= '0;
        end else begin
            if (score_inc)
                bus.score <= sat_inc(bus.score);
            if (miss_inc)
                bus.misses <= sat_inc(bus.misses);
        end
    end
endmodule

// File: tb/tb_mole_hit_judge.sv
// Randomised press-level bench for mole_hit_judge against a per-press scoring model.
`timescale 1ns/1ps
module tb_mole_hit_judge;
    localparam int NH   = 9;
    localparam int CW   = 8;
    localparam int LOCK = 150;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #10 clk = ~clk;

    mole_hit_judge_if #(.NUM_HOLES(NH), .CNT_W(CW)) bus ();

    mole_hit_judge #(
        .NUM_HOLES(NH), .CNT_W(CW), .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int hit_seen  = 0;
    int miss_seen = 0;
    int m_score = 0;
    int m_miss  = 0;
    int m_pos   = 0;

    always @(negedge clk) begin
        if (bus.hit)  hit_seen  = hit_seen + 1;
        if (bus.miss) miss_seen = miss_seen + 1;
    end

    function automatic int sat(input int v);
`ifdef MOLE_SCORE_BCD_EN
        if (v == 'h99) return v;
        if ((v % 16) == 9) return (v / 16 + 1) * 16;
        return v + 1;
`else
        return (v >= CMAX) ? v : v + 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_press(input int k, input logic [NH-1:0] moles, input logic en);
        bus.key         = 4'(k);
        bus.mole_active = moles;
        bus.game_en     = en;
        bus.valid_key   = 1'b1;
    endtask

    // Called right after valid_key rises (just past a clock edge); consumes 6 cycles.
    task automatic judge_check(input int k, input logic [NH-1:0] moles, input logic en,
                               input bit clr, output bit exp_hit, output bit exp_miss);
        bit judged;
        judged   = en && (k < NH);
        exp_hit  = judged ? moles[k] : 1'b0;
        exp_miss = judged && !exp_hit;
        tick(4);
        check("early_pulse", {bus.hit, bus.miss}, 0);
        if (clr) bus.score_clr = 1'b1;
        tick(1);
        bus.score_clr = 1'b0;
        if (clr) begin
            m_score = 0;
            m_miss  = 0;
        end else if (exp_hit) begin
            m_score = sat(m_score);
        end else if (exp_miss) begin
            m_miss = sat(m_miss);
        end
        if (judged) m_pos = k;
        check("hit",        bus.hit, exp_hit);
        check("miss",       bus.miss, exp_miss);
        check("mole_clear", bus.mole_clear, exp_hit ? (32'd1 << k) : 32'd0);
        check("hit_pos",    bus.hit_pos, m_pos);
        check("score",      bus.score, m_score);
        check("misses",     bus.misses, m_miss);
        check("busy_judge", bus.busy, 1);
        tick(1);
        check("pulse_width", {bus.hit, bus.miss, bus.mole_clear}, 0);
    endtask

    task automatic press(input int k, input logic [NH-1:0] moles, input logic en,
                         input int hold, input bit clr);
        int h0, m0;
        bit eh, em;
        h0 = hit_seen;
        m0 = miss_seen;
        drive_press(k, moles, en);
        judge_check(k, moles, en, clr, eh, em);
        if (hold > 6) tick(hold - 6);
        check("busy_held", bus.busy, 1);
        bus.valid_key = 1'b0;
        bus.key       = 4'($urandom_range(0, 15));
        tick(LOCK + 10);
        check("busy_idle",  bus.busy, 0);
        check("hit_count",  hit_seen - h0, int'(eh));
        check("miss_count", miss_seen - m0, int'(em));
        check("pos_hold",   bus.hit_pos, m_pos);
    endtask

    initial begin
        int h0, m0, nsat;
        bit eh, em;
        bus.valid_key   = 1'b0;
        bus.key         = 4'd0;
        bus.mole_active = '0;
        bus.game_en     = 1'b0;
        bus.score_clr   = 1'b0;
        tick(3);
        check("rst_hit",   bus.hit, 0);
        check("rst_miss",  bus.miss, 0);
        check("rst_clear", bus.mole_clear, 0);
        check("rst_pos",   bus.hit_pos, 0);
        check("rst_score", bus.score, 0);
        check("rst_miss_cnt", bus.misses, 0);
        check("rst_busy",  bus.busy, 0);
        reset = 1'b1;
        tick(2);

        press(4, 9'h010, 1'b1, 8, 1'b0);
        press(2, 9'h000, 1'b1, 400, 1'b0);
        press(12, 9'h1FF, 1'b1, 8, 1'b0);
        press(3, 9'h1FF, 1'b0, 8, 1'b0);

        // Second press lands inside the lockout window and must be ignored.
        h0 = hit_seen;
        m0 = miss_seen;
        drive_press(0, 9'h003, 1'b1);
        judge_check(0, 9'h003, 1'b1, 1'b0, eh, em);
        tick(4);
        bus.valid_key = 1'b0;
        tick(5);
        bus.key       = 4'd1;
        bus.valid_key = 1'b1;
        tick(10);
        bus.valid_key = 1'b0;
        tick(LOCK + 10);
        check("lock_hits",  hit_seen - h0, 1);
        check("lock_miss",  miss_seen - m0, 0);
        check("lock_pos",   bus.hit_pos, 0);
        check("lock_score", bus.score, m_score);
        press(1, 9'h003, 1'b1, 8, 1'b0);

        press(5, 9'h020, 1'b1, 8, 1'b1);

        for (int i = 0; i < 30; i++) begin
            int k;
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NH - 1);
            press(k, NH'($urandom), ($urandom_range(0, 5) != 0),
                  $urandom_range(6, 200), ($urandom_range(0, 9) == 0));
        end

        bus.score_clr = 1'b1;
        tick(1);
        bus.score_clr = 1'b0;
        m_score = 0;
        m_miss  = 0;
        check("clr_score",  bus.score, 0);
        check("clr_misses", bus.misses, 0);

`ifdef MOLE_SCORE_BCD_EN
        nsat = 102;
`else
        nsat = CMAX + 3;
`endif
        for (int i = 0; i < nsat; i++)
            press($urandom_range(0, NH - 1), 9'h1FF, 1'b1, 6, 1'b0);
`ifdef MOLE_SCORE_BCD_EN
        check("sat_score", bus.score, 'h99);
`else
        check("sat_score", bus.score, CMAX);
`endif

        // Reset lands 100 cycles into lockout while the key stays held.
        drive_press(6, 9'h040, 1'b1);
        judge_check(6, 9'h040, 1'b1, 1'b0, eh, em);
        tick(99);
        reset = 1'b0;
        #1;
        m_score = 0;
        m_miss  = 0;
        m_pos   = 0;
        check("mid_rst_outs", {bus.hit, bus.miss, bus.mole_clear, bus.hit_pos}, 0);
        check("mid_rst_score", bus.score, 0);
        check("mid_rst_misses", bus.misses, 0);
        check("mid_rst_busy", bus.busy, 0);
        tick(3);
        reset = 1'b1;
        h0 = hit_seen;
        judge_check(6, 9'h040, 1'b1, 1'b0, eh, em);
        tick(10);
        bus.valid_key = 1'b0;
        tick(LOCK + 10);
        check("rerise_hits", hit_seen - h0, 1);
        check("rerise_busy", bus.busy, 0);
        check("rerise_score", bus.score, m_score);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
